// File: rtl/pattern_101_pkg.sv
// pattern_101_pkg: definitions shared by the 1-0-1 detector files.
//   state_e     - 2-bit FSM encoding: IDLE=0, GOT1=1, GOT10=2, MATCH=3
//   PATTERN_LEN - length of the detected bit sequence
package pattern_101_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT1  = 2'd1,
    GOT10 = 2'd2,
    MATCH = 2'd3
  } state_e;

  localparam int PATTERN_LEN = 3;

endpackage

// File: rtl/pattern_101_sat_cnt.sv
// pattern_101_sat_cnt: generic up-counter that saturates at all-ones.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (clears the count)
//   inc - add one on this edge unless already saturated
//   cnt - current count, W bits
module pattern_101_sat_cnt
  import pattern_101_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Hold at all-ones instead of wrapping back to zero.
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pattern_101_det.sv
// pattern_101_det: Moore FSM that flags every (overlapping) 1-0-1 sequence
// on a serial input with a one-cycle pulse.
// Optional feature: define PATTERN_101_CNT_EN to add the det_cnt port and a
// CNT_W-bit saturating match counter.
// Ports:
//   in_clk  - rising-edge clock
//   in_rst  - asynchronous active-high reset
//   in_p    - serial data bit, sampled every rising edge
//   o_d     - detect flag, high while the FSM sits in MATCH
//   det_cnt - matches since reset, saturating (PATTERN_101_CNT_EN only)
module pattern_101_det
  import pattern_101_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_p,
  output logic             o_d
`ifdef PATTERN_101_CNT_EN
  ,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("pattern_101_det: CNT_W must be at least 1");
  end

  state_e p_st_q;
  state_e p_st_d;
  // Named state view kept for hierarchical probing.
  state_e p_st;

  always_comb begin
    p_st_d = p_st_q;
    unique case (p_st_q)
      IDLE:    p_st_d = in_p ? GOT1  : IDLE;
      GOT1:    p_st_d = in_p ? GOT1  : GOT10;
      GOT10:   p_st_d = in_p ? MATCH : IDLE;
      // Overlap: a trailing "1" or "10" of this match starts the next one.
      MATCH:   p_st_d = in_p ? GOT1  : GOT10;
      default: p_st_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      p_st_q <= IDLE;
    end else begin
      p_st_q <= p_st_d;
    end
  end

  assign p_st = p_st_q;
  assign o_d  = (p_st_q == MATCH);

`ifdef PATTERN_101_CNT_EN
  // Counting on the next state makes det_cnt step on the same edge o_d rises.
  logic cnt_inc;
  assign cnt_inc = (p_st_d == MATCH);

  pattern_101_sat_cnt #(
    .W (CNT_W)
  ) u_sat_cnt (
    .clk (in_clk),
    .rst (in_rst),
    .inc (cnt_inc),
    .cnt (det_cnt)
  );
`endif

endmodule

// File: tb/tb_pattern_101_det.sv
module tb_pattern_101_det;

  localparam int TB_CNT_W = 2;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  logic in_p   = 1'b0;
  logic o_d;
`ifdef PATTERN_101_CNT_EN
  logic [TB_CNT_W-1:0] det_cnt;
`endif

  pattern_101_det #(
    .CNT_W (TB_CNT_W)
  ) dut (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .in_p    (in_p),
    .o_d     (o_d)
`ifdef PATTERN_101_CNT_EN
    ,
    .det_cnt (det_cnt)
`endif
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: last three bits sampled since reset, plus a match count.
  logic [2:0] hist;
  int         ref_cnt;
  int         pulses;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_state();
    if (hist == 3'b101)      return 2'd3;
    if (hist[1:0] == 2'b10)  return 2'd2;
    if (hist[0])             return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".p_st"}, 32'(dut.p_st), 32'(ref_state()));
    check_eq({tag, ".o_d"},  32'(o_d),      32'(ref_state() == 2'd3));
`ifdef PATTERN_101_CNT_EN
    check_eq({tag, ".det_cnt"}, 32'(det_cnt), 32'(ref_cnt));
`endif
  endtask

  // Apply one bit, let it be sampled, then compare just after the edge.
  task automatic drive_bit(input logic b, input string tag);
    in_p = b;
    @(posedge in_clk);
    #1;
    hist = {hist[1:0], b};
    if (hist == 3'b101) begin
      pulses++;
      if (ref_cnt < (1 << TB_CNT_W) - 1) ref_cnt++;
    end
    check_all(tag);
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    hist = 3'b000;
    ref_cnt = 0;
    pulses = 0;
    #1;
    check_all("rst_async");
    in_p = 1'b1;
    repeat (2) begin
      @(posedge in_clk);
      #1;
      check_all("rst_hold");
    end
    #9;
    in_rst = 1'b0;
    in_p = 1'b0;
  endtask

  initial begin
    logic [31:0] stream;
    logic [31:0] pulse_mask;
    logic [31:0] exp_mask;
    logic [4:0]  sat_seq [0:3];

    hist = 3'b000;
    ref_cnt = 0;
    pulses = 0;
    @(posedge in_clk);
    #3;
    do_reset();

    // Basic match, then one extra bit to see the pulse drop.
    drive_bit(1'b1, "basic0");
    drive_bit(1'b0, "basic1");
    drive_bit(1'b1, "basic2");
    check_eq("basic_pulse", 32'(o_d), 32'd1);
    drive_bit(1'b1, "basic3");
    check_eq("basic_pulse_end", 32'(o_d), 32'd0);

    // Overlap 1,0,1,0,1.
    do_reset();
    foreach (sat_seq[i]) sat_seq[i] = 5'b10101;
    for (int i = 4; i >= 0; i--) drive_bit(sat_seq[0][i], "ovl");
    check_eq("ovl_pulses", 32'(pulses), 32'd2);
`ifdef PATTERN_101_CNT_EN
    check_eq("ovl_det_cnt", 32'(det_cnt), 32'd2);
`endif

    // Reference stream, MSB first; record the pulse position per bit.
    do_reset();
    stream = 32'b00110010001010110010010001011101;
    pulse_mask = '0;
    for (int i = 0; i < 32; i++) begin
      drive_bit(stream[31 - i], "stream");
      pulse_mask[i] = o_d;
    end
    exp_mask = (32'd1 << 12) | (32'd1 << 14) | (32'd1 << 27) | (32'd1 << 31);
    check_eq("stream_mask", pulse_mask, exp_mask);
    check_eq("stream_pulses", 32'(pulses), 32'd4);

    // Non-matching sequences.
    do_reset();
    drive_bit(1'b1, "nm_a"); drive_bit(1'b1, "nm_a"); drive_bit(1'b0, "nm_a");
    drive_bit(1'b0, "nm_a"); drive_bit(1'b1, "nm_a");
    do_reset();
    drive_bit(1'b1, "nm_b"); drive_bit(1'b0, "nm_b");
    drive_bit(1'b0, "nm_b"); drive_bit(1'b1, "nm_b");
    check_eq("nm_pulses", 32'(pulses), 32'd0);

    // Mid-pattern asynchronous reset.
    do_reset();
    drive_bit(1'b1, "mid0");
    drive_bit(1'b0, "mid1");
    #3;
    in_rst = 1'b1;
    hist = 3'b000;
    ref_cnt = 0;
    #1;
    check_all("mid_async");
    #2;
    in_rst = 1'b0;
    drive_bit(1'b1, "mid2");
    check_eq("mid_got1", 32'(dut.p_st), 32'd1);
    check_eq("mid_no_pulse", 32'(o_d), 32'd0);

    // Five overlapping matches: counter must saturate at 3.
    do_reset();
    drive_bit(1'b1, "sat");
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b0, "sat");
      drive_bit(1'b1, "sat");
    end
    check_eq("sat_pulses", 32'(pulses), 32'd5);
`ifdef PATTERN_101_CNT_EN
    check_eq("sat_det_cnt", 32'(det_cnt), 32'd3);
`endif

    // Random stream with occasional resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive_bit(1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
